// File: rtl/rf_pkg.sv
// Shared register-file package: widths, queue depth and the queue entry layout.
package rf_pkg;

    localparam int RF_REG_W    = 3;
    localparam int RF_DATA_W   = 16;
    localparam int RF_NUM_REGS = 8;
    localparam int RFQ_DEPTH   = 4;

    // One pending register write as seen by the forwarding lookups.
    typedef struct packed {
        logic                 valid;
        logic [RF_REG_W-1:0]  regsel;
        logic [RF_DATA_W-1:0] data;
    } rfq_entry_t;

endpackage

// File: rtl/rf_write_queue_if.sv
// Writeback-side request handshake plus the rf single write port.
// The queue uses the slave modport; whoever drives requests uses master.
interface rf_write_queue_if
    import rf_pkg::*;
#(
    parameter int REG_W  = RF_REG_W,
    parameter int DATA_W = RF_DATA_W
);

    logic              inValid;
    logic              inReady;
    logic [REG_W-1:0]  inReg;
    logic [DATA_W-1:0] inData;
    logic              rfStall;
    logic              writeEn;
    logic [REG_W-1:0]  writeRegSel;
    logic [DATA_W-1:0] writeData;

    modport master (
        output inValid, inReg, inData, rfStall,
        input  inReady, writeEn, writeRegSel, writeData
    );

    modport slave (
        input  inValid, inReg, inData, rfStall,
        output inReady, writeEn, writeRegSel, writeData
    );

endinterface

// File: rtl/rf_write_queue_match.sv
// Youngest-first forwarding match over the occupied queue entries.
// Entries are visited oldest to youngest starting at the head, so the last
// match found is the youngest one and pointer wrap does not disturb ordering.
module rf_write_queue_match
    import rf_pkg::*;
#(
    parameter int DEPTH = RFQ_DEPTH
) (
    input  rfq_entry_t                 entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   head,
    input  logic [RF_REG_W-1:0]        sel,
    output logic                       hit,
    output logic [RF_DATA_W-1:0]       data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    // Scan by age offset from the head; a younger match overrides an older one.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned and no latch is inferred.
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (entries[idx].valid && (entries[idx].regsel == sel)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/rf_write_queue.sv
// Buffered in-order write queue in front of the 8x16 register file.
// Accepts writes over valid/ready, drains one per unstalled cycle into the rf
// write port, and forwards the youngest pending value to two lookup ports.
// REG_W/DATA_W must match the rf_pkg widths used by the entry struct.
module rf_write_queue
    import rf_pkg::*;
#(
    parameter int DEPTH  = RFQ_DEPTH,
    parameter int DATA_W = RF_DATA_W,
    parameter int REG_W  = RF_REG_W
) (
    input  logic                     clk,
    input  logic                     rst,
    rf_write_queue_if.slave          bus,
    input  logic [REG_W-1:0]         lkp1Sel,
    input  logic [REG_W-1:0]         lkp2Sel,
    output logic                     lkp1Hit,
    output logic                     lkp2Hit,
    output logic [DATA_W-1:0]        lkp1Data,
    output logic [DATA_W-1:0]        lkp2Data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [DEPTH-1:0]  valid_q;
    logic [REG_W-1:0]  reg_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    rfq_entry_t        entries  [DEPTH];
    logic              push;
    logic              pop;

    // Flow control depends only on registered occupancy, never on rfStall.
    assign bus.inReady = (count != CNT_W'(DEPTH));
    assign empty       = (count == '0);
    assign push        = bus.inValid && bus.inReady;

    // Drain side: the head is presented whenever the queue holds anything.
    assign bus.writeEn     = !empty && !bus.rfStall;
    assign pop             = bus.writeEn;
    assign bus.writeRegSel = empty ? '0 : reg_mem[head];
    assign bus.writeData   = empty ? '0 : data_mem[head];

    // Pointer, occupancy and valid-bit bookkeeping; reset discards pending writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            valid_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every update here sees the pre-edge values of head, tail and count.
            if (push) begin
                tail          <= tail + 1'b1;
                valid_q[tail] <= 1'b1;
            end
            if (pop) begin
                head          <= head + 1'b1;
                valid_q[head] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry payload storage written at the tail on each accepted request.
    // NOTE: payload memory is deliberately not reset; the valid bits alone decide what is occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            reg_mem[tail]  <= bus.inReg;
            data_mem[tail] <= bus.inData;
        end
    end

    // Assemble the per-slot entry view consumed by the lookup matchers.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries[i] = '{valid: valid_q[i], regsel: reg_mem[i], data: data_mem[i]};
        end
    end

    rf_write_queue_match #(.DEPTH(DEPTH)) u_match1 (
        .entries (entries),
        .head    (head),
        .sel     (lkp1Sel),
        .hit     (lkp1Hit),
        .data    (lkp1Data)
    );

    rf_write_queue_match #(.DEPTH(DEPTH)) u_match2 (
        .entries (entries),
        .head    (head),
        .sel     (lkp2Sel),
        .hit     (lkp2Hit),
        .data    (lkp2Data)
    );

endmodule

// File: tb/tb_rf_write_queue.sv
// Directed bench for rf_write_queue: reset, single write, fill under stall,
// youngest-wins forwarding, back-to-back push/pop across wrap, mid-run reset.
module tb_rf_write_queue;
    import rf_pkg::*;

    logic        clk;
    logic        rst;
    logic [2:0]  lkp1Sel;
    logic [2:0]  lkp2Sel;
    logic        lkp1Hit;
    logic        lkp2Hit;
    logic [15:0] lkp1Data;
    logic [15:0] lkp2Data;
    logic [2:0]  count;
    logic        empty;

    int checks;
    int errors;

    // Record of what reached the rf write port.
    logic [15:0] rf_model [8];
    logic [2:0]  log_reg  [$];
    logic [15:0] log_data [$];

    rf_write_queue_if #(.REG_W(3), .DATA_W(16)) bus ();

    rf_write_queue #(.DEPTH(4), .DATA_W(16), .REG_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .lkp1Sel  (lkp1Sel),
        .lkp2Sel  (lkp2Sel),
        .lkp1Hit  (lkp1Hit),
        .lkp2Hit  (lkp2Hit),
        .lkp1Data (lkp1Data),
        .lkp2Data (lkp2Data),
        .count    (count),
        .empty    (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every committed rf write.
    always @(posedge clk) begin
        if (bus.writeEn) begin
            rf_model[bus.writeRegSel] <= bus.writeData;
            log_reg.push_back(bus.writeRegSel);
            log_data.push_back(bus.writeData);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.inValid = 1'b0;
        bus.inReg   = 3'd0;
        bus.inData  = 16'h0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_inReady"}, 32'(bus.inReady), 32'd1);
        check({tag, "_empty"},   32'(empty),       32'd1);
        check({tag, "_count"},   32'(count),       32'd0);
        check({tag, "_writeEn"}, 32'(bus.writeEn), 32'd0);
        check({tag, "_wsel"},    32'(bus.writeRegSel), 32'd0);
        check({tag, "_wdata"},   32'(bus.writeData),   32'd0);
        check({tag, "_hit1"},    32'(lkp1Hit),  32'd0);
        check({tag, "_hit2"},    32'(lkp2Hit),  32'd0);
        check({tag, "_data1"},   32'(lkp1Data), 32'd0);
        check({tag, "_data2"},   32'(lkp2Data), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        bus.rfStall = 1'b0;
        lkp1Sel     = 3'd0;
        lkp2Sel     = 3'd0;
        idle_inputs();

        // Reset state.
        #2;
        check_cleared("reset");

        // Single write of r3 = 0xBEEF.
        @(negedge clk);
        rst        = 1'b0;
        bus.inValid = 1'b1;
        bus.inReg   = 3'd3;
        bus.inData  = 16'hBEEF;
        @(negedge clk);
        idle_inputs();
        lkp1Sel = 3'd3;
        #1;
        check("t1_writeEn", 32'(bus.writeEn),     32'd1);
        check("t1_wsel",    32'(bus.writeRegSel), 32'd3);
        check("t1_wdata",   32'(bus.writeData),   32'hBEEF);
        check("t1_hit1",    32'(lkp1Hit),         32'd1);
        check("t1_data1",   32'(lkp1Data),        32'hBEEF);
        check("t1_count",   32'(count),           32'd1);
        @(negedge clk);
        #1;
        check("t1_rf3",     32'(rf_model[3]),     32'hBEEF);
        check("t1_empty",   32'(empty),           32'd1);
        check("t1_idle_we", 32'(bus.writeEn),     32'd0);

        // Fill under stall: 5 offered, 4 accepted.
        base        = log_data.size();
        bus.rfStall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.inValid = 1'b1;
            bus.inReg   = 3'(i);
            bus.inData  = 16'h1000 + 16'(i);
            @(negedge clk);
        end
        idle_inputs();
        #1;
        check("t2_count",   32'(count),           32'd4);
        check("t2_inReady", 32'(bus.inReady),     32'd0);
        check("t2_stallwe", 32'(bus.writeEn),     32'd0);
        check("t2_headsel", 32'(bus.writeRegSel), 32'd0);
        check("t2_headdat", 32'(bus.writeData),   32'h1000);
        check("t2_nowrite", 32'(log_data.size()), 32'(base));
        bus.rfStall = 1'b0;
        @(negedge clk);
        #1;
        check("t2_ready1",  32'(bus.inReady),     32'd1);
        check("t2_count3",  32'(count),           32'd3);
        repeat (3) @(negedge clk);
        #1;
        check("t2_drained", 32'(count),           32'd0);
        check("t2_nwrites", 32'(log_data.size()), 32'(base + 4));
        for (int i = 0; i < 4; i++) begin
            if (base + i < log_data.size()) begin
                check("t2_ord_reg",  32'(log_reg[base + i]),  32'(i));
                check("t2_ord_data", 32'(log_data[base + i]), 32'h1000 + 32'(i));
            end
        end

        // Youngest-wins forwarding on r5.
        base        = log_data.size();
        bus.rfStall = 1'b1;
        bus.inValid = 1'b1;
        bus.inReg   = 3'd5;
        bus.inData  = 16'h0001;
        @(negedge clk);
        bus.inData  = 16'h0002;
        @(negedge clk);
        idle_inputs();
        lkp2Sel = 3'd5;
        lkp1Sel = 3'd3;
        #1;
        check("t3_hit2",    32'(lkp2Hit),  32'd1);
        check("t3_data2",   32'(lkp2Data), 32'h0002);
        check("t3_miss1",   32'(lkp1Hit),  32'd0);
        check("t3_missd1",  32'(lkp1Data), 32'd0);
        bus.rfStall = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("t3_rf5",     32'(rf_model[5]),     32'h0002);
        check("t3_hit2off", 32'(lkp2Hit),         32'd0);
        check("t3_nwrites", 32'(log_data.size()), 32'(base + 2));
        if (base + 1 < log_data.size()) begin
            check("t3_first",  32'(log_data[base]),     32'h0001);
            check("t3_second", 32'(log_data[base + 1]), 32'h0002);
        end

        // Ten back-to-back pushes with no stall, crossing pointer wrap.
        base = log_data.size();
        for (int i = 0; i < 10; i++) begin
            bus.inValid = 1'b1;
            bus.inReg   = 3'(i);
            bus.inData  = 16'hA000 + 16'(i);
            @(negedge clk);
            #1;
            check("t4_count1", 32'(count), 32'd1);
        end
        idle_inputs();
        @(negedge clk);
        #1;
        check("t4_empty",   32'(count),           32'd0);
        check("t4_nwrites", 32'(log_data.size()), 32'(base + 10));
        for (int i = 0; i < 10; i++) begin
            if (base + i < log_data.size()) begin
                check("t4_ord_reg",  32'(log_reg[base + i]),  32'(i % 8));
                check("t4_ord_data", 32'(log_data[base + i]), 32'hA000 + 32'(i));
            end
        end

        // Asynchronous reset with three entries pending.
        bus.rfStall = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus.inValid = 1'b1;
            bus.inReg   = 3'(i);
            bus.inData  = 16'hC000 + 16'(i);
            @(negedge clk);
        end
        idle_inputs();
        lkp1Sel = 3'd1;
        lkp2Sel = 3'd3;
        #1;
        check("t5_count3",  32'(count),   32'd3);
        check("t5_prehit",  32'(lkp2Hit), 32'd1);
        base = log_data.size();
        #1;
        rst = 1'b1;
        #1;
        check_cleared("t5_rst");
        bus.rfStall = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("t5_nowrite", 32'(log_data.size()), 32'(base));
        check("t5_count0",  32'(count),           32'd0);
        check("t5_we",      32'(bus.writeEn),     32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
